// File: rtl/read_engine_pkg.sv
// Shared types and constants for the AFU read-request engine and its
// control-block decode.
package interface_debug;

    localparam int CL_ADDR_W     = 42;
    localparam int MDATA_W       = 16;

    // Control-block field offsets in bits, plus the byte-to-cache-line shift.
    localparam int CB_CODE_LSB      = 0;
    localparam int CB_NUM_LINES_LSB = 32;
    localparam int CB_BASE_LSB      = 64;
    localparam int CL_BYTE_SHIFT    = 6;

    typedef logic [31:0]          t_uint32;
    typedef logic [CL_ADDR_W-1:0] t_cl_addr;

    typedef enum logic [1:0] {
        AFU_IDLE = 2'd0,
        AFU_CTRL = 2'd1,
        AFU_RUN  = 2'd2,
        AFU_DONE = 2'd3
    } e_afu_state;

    typedef enum logic [2:0] {
        R_IDLE      = 3'd0,
        R_CTRL_REQ  = 3'd1,
        R_CTRL_WAIT = 3'd2,
        R_RUN       = 3'd3,
        R_DONE      = 3'd4
    } e_read_state;

    localparam logic [MDATA_W-1:0] READ_CTRL_MDATA   = 16'h0001;
    localparam logic [MDATA_W-1:0] READ_RUN_MDATA    = 16'h0002;
    localparam t_uint32            CONTROL_START_RUN = 32'h0000_0001;

endpackage

// File: rtl/read_engine_if.sv
// Control-response interface: the parent drives valid/data, and the
// control-block fields are decoded combinationally for the read engine.
interface ctrl_resp_if
    import interface_debug::*;
(
    input logic clk,
    input logic reset
);
    logic         valid;
    logic [511:0] data;
    t_uint32      code;
    t_uint32      num_lines;
    t_cl_addr     base_addr;

    logic [63:0]  w_base_byte;
    logic         w_unused_bits;

    assign code        = data[CB_CODE_LSB +: 32];
    assign num_lines   = data[CB_NUM_LINES_LSB +: 32];
    assign w_base_byte = data[CB_BASE_LSB +: 64];
    // Byte address to cache-line address, truncated to the CL width.
    assign base_addr   = w_base_byte[CL_BYTE_SHIFT +: CL_ADDR_W];

    assign w_unused_bits = ^{data[511:128], w_base_byte[63:48], w_base_byte[5:0], clk, reset};

    modport master (input clk, input reset, output valid, output data);
    modport slave  (input clk, input reset, input valid, input code,
                    input num_lines, input base_addr);
endinterface

// File: rtl/read_engine.sv
// Read-request generator: one control-block read, then sequential cache-line
// reads over the described buffer. Define READ_ENGINE_CTRL_POLL_EN to re-read
// the control block until a START_RUN code arrives.
module read_engine
    import interface_debug::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [1:0]         afu_state,
    input  t_cl_addr           ctrl_addr,
    ctrl_resp_if.slave         ctrl_resp,
    output logic               rd_valid,
    output logic [MDATA_W-1:0] mdata,
    output t_cl_addr           addr
);
    e_read_state        r_state;
    e_read_state        w_state_nxt;
    t_uint32            r_idx;
    t_uint32            w_idx_nxt;
    t_uint32            r_num_lines;
    t_uint32            w_num_lines_nxt;
    t_cl_addr           r_base;
    t_cl_addr           w_base_nxt;
    logic               r_rd_valid;
    logic               w_rd_valid;
    logic [MDATA_W-1:0] r_mdata;
    logic [MDATA_W-1:0] w_mdata;
    t_cl_addr           r_addr;
    t_cl_addr           w_addr;

    assign rd_valid = r_rd_valid;
    assign mdata    = r_mdata;
    assign addr     = r_addr;

    // Next-state and next-request decode; an idle AFU aborts any activity.
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_num_lines_nxt = r_num_lines;
        w_base_nxt      = r_base;
        w_rd_valid      = 1'b0;
        w_mdata         = r_mdata;
        w_addr          = r_addr;
        if ((r_state != R_IDLE) && (afu_state == AFU_IDLE)) begin
            w_state_nxt = R_IDLE;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (afu_state == AFU_CTRL) begin
                        w_state_nxt = R_CTRL_REQ;
                    end else begin
                        w_state_nxt = R_IDLE;
                    end
                end
                R_CTRL_REQ: begin
                    if (!stall) begin
                        w_rd_valid  = 1'b1;
                        w_addr      = ctrl_addr;
                        w_mdata     = READ_CTRL_MDATA;
                        w_state_nxt = R_CTRL_WAIT;
                    end else begin
                        w_state_nxt = R_CTRL_REQ;
                    end
                end
                R_CTRL_WAIT: begin
                    if (ctrl_resp.valid && (ctrl_resp.code == CONTROL_START_RUN)) begin
                        w_base_nxt      = ctrl_resp.base_addr;
                        w_num_lines_nxt = ctrl_resp.num_lines;
                        w_idx_nxt       = 32'd0;
                        w_state_nxt     = R_RUN;
`ifdef READ_ENGINE_CTRL_POLL_EN
                    end else if (ctrl_resp.valid) begin
                        w_state_nxt = R_CTRL_REQ;
`endif
                    end else begin
                        w_state_nxt = R_CTRL_WAIT;
                    end
                end
                R_RUN: begin
                    // idx only ever counts up to num_lines, so equality marks the end.
                    if (r_idx == r_num_lines) begin
                        w_state_nxt = R_DONE;
                    end else if ((afu_state == AFU_RUN) && !stall) begin
                        w_rd_valid = 1'b1;
                        w_addr     = r_base + CL_ADDR_W'(r_idx);
                        w_mdata    = READ_RUN_MDATA;
                        w_idx_nxt  = r_idx + 32'd1;
                    end else begin
                        w_state_nxt = R_RUN;
                    end
                end
                R_DONE: begin
                    w_state_nxt = R_DONE;
                end
                default: begin
                    w_state_nxt = R_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered request outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= R_IDLE;
            r_idx       <= 32'd0;
            r_num_lines <= 32'd0;
            r_base      <= '0;
            r_rd_valid  <= 1'b0;
            r_mdata     <= '0;
            r_addr      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_num_lines <= w_num_lines_nxt;
            r_base      <= w_base_nxt;
            r_rd_valid  <= w_rd_valid;
            r_mdata     <= w_mdata;
            r_addr      <= w_addr;
        end
    end

endmodule

// File: tb/tb_read_engine.sv
// Self-checking bench for read_engine: a transaction-level model of the
// request stream is compared every cycle, plus literal checks of the logged requests.
module tb_read_engine;
    import interface_debug::*;

`ifdef READ_ENGINE_CTRL_POLL_EN
    localparam bit POLL = 1'b1;
`else
    localparam bit POLL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  afu_state;
    logic [41:0] ctrl_addr;
    logic        rd_valid;
    logic [15:0] mdata;
    logic [41:0] addr;

    int checks = 0;
    int errors = 0;

    logic [41:0] log_addr[$];
    logic [15:0] log_mdata[$];

    always #5 clk = ~clk;

    ctrl_resp_if u_if (.clk(clk), .reset(reset));

    read_engine dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .afu_state (afu_state),
        .ctrl_addr (ctrl_addr),
        .ctrl_resp (u_if),
        .rd_valid  (rd_valid),
        .mdata     (mdata),
        .addr      (addr)
    );

    // Model: owed control read, awaiting response, lines remaining, next address.
    bit          m_active, m_owed, m_wait, m_run;
    logic [31:0] m_left;
    logic [41:0] m_next;
    logic        exp_valid;
    logic [41:0] exp_addr;
    logic [15:0] exp_mdata;

    function automatic logic [41:0] cl_of(input logic [63:0] byte_addr);
        return 42'(byte_addr / 64'd64);
    endfunction

    always @(posedge clk) begin
        exp_valid <= 1'b0;
        if (reset) begin
            m_active <= 1'b0; m_owed <= 1'b0; m_wait <= 1'b0; m_run <= 1'b0;
            m_left <= 32'd0; m_next <= 42'd0;
            exp_addr <= 42'd0; exp_mdata <= 16'd0;
        end else if (!m_active) begin
            if (afu_state == AFU_CTRL) begin
                m_active <= 1'b1;
                m_owed   <= 1'b1;
            end
        end else if (afu_state == AFU_IDLE) begin
            m_active <= 1'b0; m_owed <= 1'b0; m_wait <= 1'b0; m_run <= 1'b0;
        end else if (m_owed) begin
            if (!stall) begin
                exp_valid <= 1'b1;
                exp_addr  <= ctrl_addr;
                exp_mdata <= 16'h0001;
                m_owed    <= 1'b0;
                m_wait    <= 1'b1;
            end
        end else if (m_wait) begin
            if (u_if.valid) begin
                if (u_if.data[31:0] == 32'd1) begin
                    m_wait <= 1'b0;
                    m_run  <= 1'b1;
                    m_left <= u_if.data[63:32];
                    m_next <= cl_of(u_if.data[127:64]);
                end else if (POLL) begin
                    m_wait <= 1'b0;
                    m_owed <= 1'b1;
                end
            end
        end else if (m_run) begin
            if (m_left == 32'd0) begin
                m_run <= 1'b0;
            end else if ((afu_state == AFU_RUN) && !stall) begin
                exp_valid <= 1'b1;
                exp_addr  <= m_next;
                exp_mdata <= 16'h0002;
                m_next    <= m_next + 42'd1;
                m_left    <= m_left - 32'd1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // One cycle: compare against the model on the falling edge and log requests.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rd_valid", 64'(rd_valid), 64'(exp_valid));
            check("addr", 64'(addr), 64'(exp_addr));
            check("mdata", 64'(mdata), 64'(exp_mdata));
            if (rd_valid === 1'b1) begin
                log_addr.push_back(addr);
                log_mdata.push_back(mdata);
            end
        end
    endtask

    task automatic send_resp(input logic [31:0] code, input logic [31:0] num, input logic [63:0] base_byte);
        u_if.data  = {384'd0, base_byte, num, code};
        u_if.valid = 1'b1;
        tick();
        u_if.valid = 1'b0;
    endtask

    task automatic expect_entry(input string name, input int i, input logic [41:0] a, input logic [15:0] m);
        if (i < log_addr.size()) begin
            check({name, "_addr"}, 64'(log_addr[i]), 64'(a));
            check({name, "_mdata"}, 64'(log_mdata[i]), 64'(m));
        end else begin
            checks++;
            errors++;
            $display("FAIL %s missing entry %0d (have %0d)", name, i, log_addr.size());
        end
    endtask

    task automatic go_idle();
        afu_state = AFU_IDLE;
        stall = 1'b0;
        tick(2);
        log_addr.delete();
        log_mdata.delete();
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; afu_state = AFU_IDLE; ctrl_addr = 42'd0;
        u_if.valid = 1'b0; u_if.data = 512'd0;
        tick(3);
        check("reset_rd_valid", 64'(rd_valid), 64'd0);
        check("reset_addr", 64'(addr), 64'd0);
        check("reset_mdata", 64'(mdata), 64'd0);
        reset = 1'b0;
        tick();

        // Single control read.
        afu_state = AFU_CTRL; ctrl_addr = 42'h100;
        tick(6);
        check("t1_count", 64'(log_addr.size()), 64'd1);
        expect_entry("t1_ctrl", 0, 42'h100, 16'h0001);

        // START_RUN with four lines, then a stray response that must be ignored.
        send_resp(32'd1, 32'd4, 64'h4000);
        afu_state = AFU_RUN;
        tick(8);
        check("t2_count", 64'(log_addr.size()), 64'd5);
        for (int i = 0; i < 4; i++) expect_entry("t2_data", i + 1, 42'h100 + 42'(i), 16'h0002);
        send_resp(32'd1, 32'd4, 64'h4000);
        tick(3);
        check("t2_stray", 64'(log_addr.size()), 64'd5);
        go_idle();

        // Stall held on the control read, then on two data cycles.
        afu_state = AFU_CTRL; stall = 1'b1;
        tick(10);
        check("t3_held", 64'(log_addr.size()), 64'd0);
        stall = 1'b0;
        tick(4);
        afu_state = AFU_RUN;
        send_resp(32'd1, 32'd4, 64'h4000);
        tick();
        stall = 1'b1;
        tick(2);
        stall = 1'b0;
        tick(6);
        check("t3_count", 64'(log_addr.size()), 64'd5);
        for (int i = 0; i < 4; i++) expect_entry("t3_data", i + 1, 42'h100 + 42'(i), 16'h0002);
        go_idle();

        // Non-START_RUN response, then START_RUN with zero lines.
        afu_state = AFU_CTRL; ctrl_addr = 42'h155;
        tick(4);
        send_resp(32'd0, 32'd4, 64'h4000);
        tick(6);
        check("t4_count", 64'(log_addr.size()), POLL ? 64'd2 : 64'd1);
        if (POLL) expect_entry("t4_poll", 1, 42'h155, 16'h0001);
        afu_state = AFU_RUN;
        send_resp(32'd1, 32'd0, 64'h4000);
        tick(8);
        check("t4_zero", 64'(log_addr.size()), POLL ? 64'd2 : 64'd1);
        go_idle();

        // Abort after two of eight data reads, then a fresh control read.
        afu_state = AFU_CTRL; ctrl_addr = 42'h100;
        tick(4);
        afu_state = AFU_RUN;
        send_resp(32'd1, 32'd8, 64'h8000);
        for (int i = 0; i < 50 && log_addr.size() < 3; i++) tick();
        check("t5_reached", 64'(log_addr.size()), 64'd3);
        afu_state = AFU_IDLE;
        tick(5);
        check("t5_stopped", 64'(log_addr.size()), 64'd3);
        expect_entry("t5_data", 1, 42'h200, 16'h0002);
        expect_entry("t5_data", 2, 42'h201, 16'h0002);
        afu_state = AFU_CTRL;
        tick(4);
        check("t5_restart", 64'(log_addr.size()), 64'd4);
        expect_entry("t5_ctrl", 3, 42'h100, 16'h0001);
        go_idle();

        // Address wrap at the top of the cache-line space.
        afu_state = AFU_CTRL;
        tick(4);
        afu_state = AFU_RUN;
        send_resp(32'd1, 32'd2, 64'hFFFF_FFFF_FFC0);
        tick(8);
        check("t6_count", 64'(log_addr.size()), 64'd3);
        expect_entry("t6_wrap", 1, 42'h3FF_FFFF_FFFF, 16'h0002);
        expect_entry("t6_wrap", 2, 42'h0, 16'h0002);
        go_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/read_engine.md
Name: read_engine

Overview:
- Read-request generator for the AFU. It issues one control-block read and decodes the control response through a ctrl_resp_if interface.
- On a START_RUN code it streams sequential cache-line reads over the data buffer described by the control block.
- Its outputs feed the parent's c0Tx header generation, registered one more time there.
- Flow control is a single stall input: c0TxAlmFull OR the response-FIFO overflow risk.

Parameters:
- CL_ADDR_W, 42, cache-line address width (t_ccip_clAddr).
- MDATA_W, 16, request metadata width.
- CTRL_MDATA, 16'h0001, mdata tag for the control read (package constant READ_CTRL_MDATA).
- RUN_MDATA, 16'h0002, mdata tag for data reads (package constant READ_RUN_MDATA).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  when 1, no request may be issued in this cycle.
- afu_state  in  2  e_afu_state: AFU_IDLE=0, AFU_CTRL=1, AFU_RUN=2, AFU_DONE=3.
- ctrl_addr  in  CL_ADDR_W  cache-line address of the control block.
- ctrl_resp  ctrl_resp_if  -  control response; fields valid, data[511:0], code, num_lines, base_addr.
- rd_valid  out  1  one-cycle read-request strobe.
- mdata  out  MDATA_W  tag of the current request.
- addr  out  CL_ADDR_W  cache-line address of the current request.

Behaviour:
- ctrl_resp_if is clocked by clk/reset, with valid and data driven by the parent. It decodes data purely combinationally:
  - code = data[31:0]
  - num_lines = data[63:32]
  - base_addr = data[127:64] >> 6, i.e. byte address to CL address, truncated to CL_ADDR_W.
  - CONTROL_START_RUN = 32'h1.
- All outputs are registered. stall, afu_state and ctrl_resp are sampled in cycle N; the request appears in cycle N+1.
- Reset: rd_valid=0, mdata=0, addr=0, internal state R_IDLE, counters 0.
- rd_valid is deasserted every cycle unless a request is issued. mdata and addr hold their last values when rd_valid=0.
- Internal FSM:
  - R_IDLE: if afu_state==AFU_CTRL, go to R_CTRL_REQ.
  - R_CTRL_REQ: when !stall, issue rd_valid=1, addr=ctrl_addr, mdata=CTRL_MDATA; go to R_CTRL_WAIT. Exactly one control request is issued.
  - R_CTRL_WAIT: on ctrl_resp.valid && code==CONTROL_START_RUN, latch base_addr and num_lines, clear idx, go to R_RUN.
    - A valid response with any other code is ignored; remain in R_CTRL_WAIT.
  - R_RUN: requests are issued only while afu_state==AFU_RUN; otherwise wait.
    - When idx<num_lines && !stall: issue rd_valid=1, addr=base+idx (modulo 2^CL_ADDR_W), mdata=RUN_MDATA; idx++.
    - When idx==num_lines: go to R_DONE.
    - num_lines==0: go straight to R_DONE with zero data requests.
  - R_DONE: no requests. Return to R_IDLE when afu_state==AFU_IDLE.
- Abort: if afu_state==AFU_IDLE in any non-idle state, return to R_IDLE next cycle with no request in that cycle.
- ctrl_resp.valid outside R_CTRL_WAIT is ignored.
- Stall asserted continuously: the request is held off indefinitely, with no loss and no duplication. The address sequence is gap-free across stalls.
- idx and num_lines are 32-bit unsigned.

Optional Feature:
- Macro: READ_ENGINE_CTRL_POLL_EN.
- Defined: in R_CTRL_WAIT, a valid response with code!=CONTROL_START_RUN returns the FSM to R_CTRL_REQ. The engine re-reads the control block until START_RUN arrives, polling the CPU-written flag.
- Undefined: non-START_RUN responses are ignored, and only one control read is ever issued per run.

Decomposition:
- Package interface_debug holds:
  - e_afu_state
  - READ_CTRL_MDATA, READ_RUN_MDATA, CONTROL_START_RUN
  - control-block field offsets
  - t_uint32
- Sub-module: ctrl_resp_if, an interface with modport for the decode. read_engine is a single module containing the FSM.

Test Plan:
- Reset, then afu_state=AFU_CTRL, ctrl_addr=42'h100, stall=0 -> a single cycle of rd_valid=1, addr=42'h100, mdata=16'h0001; no further requests.
- Control response code=1, num_lines=4, base byte addr=64'h4000, then afu_state=AFU_RUN -> 4 consecutive rd_valid pulses, addr=42'h100..42'h103, mdata=16'h0002, then silence.
- Same as above with stall high on the 2nd and 3rd eligible cycles -> still exactly 4 requests, addresses 0x100..0x103 in order, none issued while stalled (1-cycle latency).
- Response code=0 -> no data reads and the FSM stays waiting. With READ_ENGINE_CTRL_POLL_EN, a second control read (addr=ctrl_addr, mdata=1) follows the response.
- num_lines=0 -> zero data requests. Also: afu_state forced to AFU_IDLE mid-run after 2 of 8 requests -> requests stop, and a new AFU_CTRL issues a fresh control read.
- Base CL address 42'h3FF_FFFF_FFFF with num_lines=2 -> addresses 42'h3FF_FFFF_FFFF then 42'h0 (wrap).
